// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern table, blank code and scan-capture FSM states
package seg7_pkg;

  // Index = hex digit, bits = {g,f,e,d,c,b,a}; same table the binary-to-7-segment encoder drives.
  localparam logic [6:0] SEG7_PATTERNS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG7_BLANK = 7'h00;

  typedef enum logic {
    SCAN  = 1'b0,
    CHECK = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_pattern_to_bin.sv
// rtl/seg7_pattern_to_bin.sv - 7-segment pattern to {valid, nibble} lookup
// SEG7_BLANK_AS_ZERO_EN: when defined, the blank pattern reads as a valid 0.
module seg7_pattern_to_bin
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       valid_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    valid_o  = 1'b0;
    nibble_o = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (pattern_i == SEG7_PATTERNS[k]) begin
        valid_o  = 1'b1;
        nibble_o = 4'(k);
      end
    end
`ifdef SEG7_BLANK_AS_ZERO_EN
    if (pattern_i == SEG7_BLANK) begin
      valid_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - recovers hex value from a multiplexed 7-segment bus with frame stability filter
// SEG7_BLANK_AS_ZERO_EN: selects blank-as-zero decoding in seg7_pattern_to_bin.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel_in,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic                    value_valid_out,
  input  logic                    value_ready_in,
  output logic                    err_out,
  output logic                    overrun_out
);

  localparam int         FW          = 4 * NUM_DIGITS;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] STABLE_CNT  = 4'(STABLE_FRAMES);

  logic [6:0]            seg_s1_q, seg_s2_q, seg_prev_q;
  logic [NUM_DIGITS-1:0] sel_s1_q, sel_s2_q, sel_prev_q;
  logic [7:0]            settle_q, settle_d;
  logic [FW-1:0]         frame_q, frame_d, last_frame_q, last_frame_d, value_q, value_d;
  logic [NUM_DIGITS-1:0] captured_q, captured_d, err_mask_q, err_mask_d;
  logic [3:0]            match_q, match_d;
  logic                  valid_q, valid_d, err_q, err_d, overrun_q, overrun_d;
  scan_state_e           state_q, state_d;

  logic       sample_same, sel_onehot, capture, publish;
  logic       pat_valid;
  logic [3:0] pat_nibble;

  seg7_pattern_to_bin u_decode (
    .pattern_i (seg_s2_q),
    .valid_o   (pat_valid),
    .nibble_o  (pat_nibble)
  );

  assign sample_same = (seg_s2_q == seg_prev_q) && (sel_s2_q == sel_prev_q);
  assign sel_onehot  = $onehot(sel_s2_q);

  // Counter saturates at SETTLE_LAST so a held strobe captures once; only a sample change re-arms it.
  always_comb begin
    settle_d = 8'd0;
    capture  = 1'b0;
    if (sample_same && sel_onehot) begin
      settle_d = (settle_q == SETTLE_LAST) ? settle_q : settle_q + 8'd1;
      capture  = (settle_q == SETTLE_LAST - 8'd1);
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    captured_d   = captured_q;
    err_mask_d   = err_mask_q;
    last_frame_d = last_frame_q;
    match_d      = match_q;
    publish      = 1'b0;
    err_d        = 1'b0;
    if (state_q == CHECK) begin
      state_d    = SCAN;
      captured_d = '0;
      err_mask_d = '0;
      if (|err_mask_q) begin
        err_d   = 1'b1;
        match_d = 4'd0;
      end else if (frame_q == last_frame_q) begin
        match_d = (match_q == 4'hF) ? match_q : match_q + 4'd1;
        publish = (match_q != STABLE_CNT) && (match_d == STABLE_CNT);
      end else begin
        last_frame_d = frame_q;
        match_d      = 4'd1;
        publish      = (STABLE_CNT == 4'd1);
      end
    end else if (&captured_q) begin
      state_d = CHECK;
    end
    // Applied after the CHECK clear so a capture landing during CHECK belongs to the new frame.
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_s2_q[i]) begin
          frame_d[4*i +: 4] = pat_nibble;
          captured_d[i]     = 1'b1;
          err_mask_d[i]     = err_mask_d[i] | ~pat_valid;
        end
      end
    end
  end

  always_comb begin
    value_d   = value_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (publish) begin
      value_d   = frame_q;
      valid_d   = 1'b1;
      overrun_d = valid_q && !value_ready_in;
    end else if (valid_q && value_ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q     <= '0;
      seg_s2_q     <= '0;
      seg_prev_q   <= '0;
      sel_s1_q     <= '0;
      sel_s2_q     <= '0;
      sel_prev_q   <= '0;
      settle_q     <= '0;
      frame_q      <= '0;
      last_frame_q <= '0;
      value_q      <= '0;
      captured_q   <= '0;
      err_mask_q   <= '0;
      match_q      <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      overrun_q    <= 1'b0;
      state_q      <= SCAN;
    end else begin
      seg_s1_q     <= seg_in;
      seg_s2_q     <= seg_s1_q;
      seg_prev_q   <= seg_s2_q;
      sel_s1_q     <= digit_sel_in;
      sel_s2_q     <= sel_s1_q;
      sel_prev_q   <= sel_s2_q;
      settle_q     <= settle_d;
      frame_q      <= frame_d;
      last_frame_q <= last_frame_d;
      value_q      <= value_d;
      captured_q   <= captured_d;
      err_mask_q   <= err_mask_d;
      match_q      <= match_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      overrun_q    <= overrun_d;
      state_q      <= state_d;
    end
  end

  assign value_out       = value_q;
  assign value_valid_out = valid_q;
  assign err_out         = err_q;
  assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - randomized frame-level bench for seg7_scan_capture
// SEG7_BLANK_AS_ZERO_EN: reference decode follows the same macro as the design.
module tb_seg7_scan_capture;

  localparam int ND     = 4;
  localparam int SETTLE = 8;
  localparam int STABLE = 3;

  localparam logic [6:0] TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  digit_sel_in;
  logic [15:0] value_out;
  logic        value_valid_out;
  logic        value_ready_in;
  logic        err_out;
  logic        overrun_out;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int ovr_cnt  = 0;
  int hs_cnt   = 0;
  logic [15:0] hs_last = '0;
  logic [15:0] hs_prev = '0;

  // Frame-level reference state
  logic [15:0] m_last  = '0;
  logic [15:0] m_value = '0;
  int          m_match = 0;
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_capture #(
    .NUM_DIGITS    (ND),
    .SETTLE_CYCLES (SETTLE),
    .STABLE_FRAMES (STABLE)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .seg_in          (seg_in),
    .digit_sel_in    (digit_sel_in),
    .value_out       (value_out),
    .value_valid_out (value_valid_out),
    .value_ready_in  (value_ready_in),
    .err_out         (err_out),
    .overrun_out     (overrun_out)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_out) err_cnt++;
      if (overrun_out) ovr_cnt++;
      if (value_valid_out && value_ready_in) begin
        hs_cnt++;
        hs_prev = hs_last;
        hs_last = value_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] tb_decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h00;
    for (int k = 0; k < 16; k++) begin
      if (TBL[k] == p) r = {1'b1, 4'(k)};
    end
`ifdef SEG7_BLANK_AS_ZERO_EN
    if (p == 7'h00) r = 5'h10;
`endif
    return r;
  endfunction

  function automatic logic [3:0][6:0] segs_of(input logic [15:0] v);
    logic [3:0][6:0] s;
    for (int d = 0; d < ND; d++) s[d] = TBL[v[4*d +: 4]];
    return s;
  endfunction

  task automatic model_frame(input logic [3:0][6:0] segs, input bit rdy,
                             output int e_err, output int e_pub, output int e_ovr, output int e_hs);
    logic [15:0] v;
    logic [4:0]  dec;
    bit          bad;
    int          prev;
    v = '0;
    bad = 1'b0;
    for (int d = 0; d < ND; d++) begin
      dec = tb_decode(segs[d]);
      if (!dec[4]) bad = 1'b1;
      v[4*d +: 4] = dec[3:0];
    end
    e_err = bad ? 1 : 0;
    e_pub = 0;
    e_ovr = 0;
    e_hs  = (m_valid && rdy) ? 1 : 0;
    if (bad) begin
      m_match = 0;
    end else if (v == m_last) begin
      prev = m_match;
      if (m_match < 15) m_match++;
      if (prev != STABLE && m_match == STABLE) e_pub = 1;
    end else begin
      m_last  = v;
      m_match = 1;
      if (STABLE == 1) e_pub = 1;
    end
    if (e_pub != 0) begin
      if (m_valid && !rdy) e_ovr = 1;
      m_value = v;
      m_valid = 1'b1;
      if (rdy) e_hs++;
    end
    if (rdy) m_valid = 1'b0;
  endtask

  // trick: ready rises exactly in the CHECK cycle of the last digit (2 sync + SETTLE + 1 clocks after its strobe)
  task automatic scan(input logic [3:0][6:0] segs, input logic [3:0] mask, input bit trick);
    for (int d = 0; d < ND; d++) begin
      if (mask[d]) begin
        digit_sel_in = 4'(1 << d);
        seg_in       = segs[d];
        if (trick && d == ND - 1) begin
          repeat (SETTLE + 3) tick();
          value_ready_in = 1'b1;
          repeat (3) tick();
        end else begin
          repeat ($urandom_range(SETTLE + 4, SETTLE + 8)) tick();
        end
        digit_sel_in = '0;
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    digit_sel_in = '0;
    repeat (8) tick();
  endtask

  task automatic run_frame(input string tag, input logic [3:0][6:0] segs, input bit rdy, input bit trick,
                           input logic [3:0] mask, input bit completes);
    int e0, o0, h0, e_err, e_pub, e_ovr, e_hs;
    logic [15:0] old_val;
    e0 = err_cnt;
    o0 = ovr_cnt;
    h0 = hs_cnt;
    old_val = m_value;
    if (completes) begin
      model_frame(segs, rdy, e_err, e_pub, e_ovr, e_hs);
    end else begin
      e_err = 0;
      e_pub = 0;
      e_ovr = 0;
      e_hs  = (m_valid && rdy) ? 1 : 0;
      if (rdy) m_valid = 1'b0;
    end
    value_ready_in = rdy && !trick;
    scan(segs, mask, trick);
    chk({tag, ":err_pulses"}, err_cnt - e0, e_err);
    chk({tag, ":overrun_pulses"}, ovr_cnt - o0, e_ovr);
    chk({tag, ":handshakes"}, hs_cnt - h0, e_hs);
    if (rdy && e_pub != 0) chk({tag, ":consumed_value"}, hs_last, m_value);
    if (e_hs == 2) chk({tag, ":consumed_old_value"}, hs_prev, old_val);
    chk({tag, ":valid"}, value_valid_out, m_valid);
    if (m_valid) chk({tag, ":value"}, value_out, m_value);
  endtask

  initial begin
    logic [15:0]     v;
    logic [15:0]     g;
    logic [3:0][6:0] s;
    logic [3:0][6:0] bad;

    rst_n          = 1'b0;
    seg_in         = '0;
    digit_sel_in   = '0;
    value_ready_in = 1'b0;
    repeat (3) tick();
    chk("reset:value", value_out, 16'h0);
    chk("reset:valid", value_valid_out, 1'b0);
    chk("reset:err", err_out, 1'b0);
    chk("reset:overrun", overrun_out, 1'b0);
    rst_n = 1'b1;
    tick();

    s = segs_of(16'h1234);
    repeat (5) run_frame("f1234", s, 1'b1, 1'b0, 4'hF, 1'b1);

    g   = 16'($urandom);
    s   = segs_of(g);
    bad = s;
    bad[1] = 7'h7E;
    repeat (2) run_frame("err_pre", s, 1'b1, 1'b0, 4'hF, 1'b1);
    run_frame("err_bad", bad, 1'b1, 1'b0, 4'hF, 1'b1);
    repeat (3) run_frame("err_post", s, 1'b1, 1'b0, 4'hF, 1'b1);

    for (int r = 0; r < 6; r++) begin
      v = 16'($urandom);
      s = segs_of(v);
      repeat ($urandom_range(1, 4)) run_frame("rand", s, 1'b1, 1'b0, 4'hF, 1'b1);
    end

    do g = 16'($urandom); while (g == m_last);
    s = segs_of(g);
    repeat (2) run_frame("glitch_pre", s, 1'b1, 1'b0, 4'hF, 1'b1);
    digit_sel_in = 4'b0001;
    seg_in       = s[0];
    repeat (5) tick();
    digit_sel_in = '0;
    repeat (3) tick();
    digit_sel_in = 4'b0011;
    repeat (20) tick();
    digit_sel_in = '0;
    repeat (3) tick();
    run_frame("glitch_rest", s, 1'b1, 1'b0, 4'b1110, 1'b0);
    run_frame("glitch_done", s, 1'b1, 1'b0, 4'b0001, 1'b1);

    s = segs_of(16'h00AB);
    repeat (3) run_frame("hold_ab", s, 1'b0, 1'b0, 4'hF, 1'b1);
    s = segs_of(16'h00CD);
    repeat (3) run_frame("hold_cd", s, 1'b0, 1'b0, 4'hF, 1'b1);

    do g = 16'($urandom); while (g == m_last);
    s = segs_of(g);
    repeat (2) run_frame("simul_pre", s, 1'b0, 1'b0, 4'hF, 1'b1);
    run_frame("simul", s, 1'b1, 1'b1, 4'hF, 1'b1);

    s = segs_of(16'h0567);
    s[3] = 7'h00;
    repeat (4) run_frame("blank", s, 1'b1, 1'b0, 4'hF, 1'b1);

    do v = 16'($urandom); while (v == m_last);
    s = segs_of(v);
    repeat (3) run_frame("pre_rst", s, 1'b0, 1'b0, 4'hF, 1'b1);
    run_frame("partial", s, 1'b0, 1'b0, 4'b0011, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst:value", value_out, 16'h0);
    chk("midrst:valid", value_valid_out, 1'b0);
    chk("midrst:err", err_out, 1'b0);
    chk("midrst:overrun", overrun_out, 1'b0);
    m_last  = '0;
    m_value = '0;
    m_match = 0;
    m_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    repeat (3) run_frame("post_rst", s, 1'b1, 1'b0, 4'hF, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
